// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_unit
// Description : Stall, flush and forwarding control for an in-order pipeline
//               with load-use, taken-branch and multi-cycle MDU hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit #(
    parameter int STAGES  = 3,
    parameter int MDU_LAT = 4,
    parameter int FWD_W   = $clog2(STAGES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       id_rd_addr_i,
    input  logic             id_rd_wren_i,
    input  logic             id_is_load_i,
    input  logic             id_is_mdu_i,
    input  logic             ex_br_taken_i,
    output logic             stall_pc_o,
    output logic             stall_ifid_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic             hold_ex_o,
    output logic             bubble_mem_o,
    output logic [FWD_W-1:0] fwd_a_o,
    output logic [FWD_W-1:0] fwd_b_o,
    output logic             mdu_busy_o,
    output logic             mdu_done_o
);

    localparam logic [4:0] MDU_LOAD = 5'(MDU_LAT - 1);

    logic [STAGES-1:0] st_valid;
    logic [STAGES-1:0] st_wren;
    logic [STAGES-1:0] st_load;
    logic [STAGES-1:0] st_mdu;
    logic [4:0]        st_rd [STAGES];
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic              ex_rs1_used;
    logic              ex_rs2_used;
    logic [4:0]        mdu_cnt;

    logic [STAGES-1:0] src;
    logic              mdu_hold;
    logic              br_flush;
    logic              load_use;
    logic              flush_idex;
    logic              id_enter;

    always_comb begin
        src = '0;
        for (int k = 0; k < STAGES; k++) begin
            src[k] = st_valid[k] & st_wren[k] & (st_rd[k] != 5'd0);
        end
    end

    assign mdu_hold = (mdu_cnt != 5'd0);
    // Branch only counts when EX really holds an instruction and MDU is idle
    assign br_flush = ex_br_taken_i & st_valid[0] & ~mdu_hold;
    assign load_use = id_valid_i & src[0] & st_load[0] & ~mdu_hold &
                      ((id_rs1_used_i & (id_rs1_addr_i == st_rd[0])) |
                       (id_rs2_used_i & (id_rs2_addr_i == st_rd[0])));
    assign flush_idex = br_flush | load_use;
    assign id_enter   = id_valid_i & ~flush_idex;

    assign stall_pc_o   = mdu_hold | (load_use & ~br_flush);
    assign stall_ifid_o = mdu_hold | (load_use & ~br_flush);
    assign flush_ifid_o = br_flush;
    assign flush_idex_o = flush_idex;
    assign hold_ex_o    = mdu_hold;
    assign bubble_mem_o = mdu_hold;
    assign mdu_busy_o   = mdu_hold;
    assign mdu_done_o   = st_valid[0] & st_mdu[0] & ~mdu_hold;

    // Descending scan so the youngest (smallest k) match wins
    always_comb begin
        fwd_a_o = '0;
        fwd_b_o = '0;
        for (int k = STAGES - 1; k >= 1; k--) begin
            if (st_valid[0] && ex_rs1_used && src[k] && (st_rd[k] == ex_rs1)) begin
                fwd_a_o = FWD_W'(k);
            end
            if (st_valid[0] && ex_rs2_used && src[k] && (st_rd[k] == ex_rs2)) begin
                fwd_b_o = FWD_W'(k);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_valid    <= '0;
            st_wren     <= '0;
            st_load     <= '0;
            st_mdu      <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st_rd[k] <= 5'd0;
            end
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rs1_used <= 1'b0;
            ex_rs2_used <= 1'b0;
            mdu_cnt     <= 5'd0;
        end else begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                st_valid[k] <= (k == 1 && mdu_hold) ? 1'b0 : st_valid[k-1];
                st_wren[k]  <= st_wren[k-1];
                st_load[k]  <= st_load[k-1];
                st_mdu[k]   <= st_mdu[k-1];
                st_rd[k]    <= st_rd[k-1];
            end
            if (mdu_hold) begin
                mdu_cnt <= mdu_cnt - 5'd1;
            end else begin
                st_valid[0] <= id_enter;
                st_wren[0]  <= id_rd_wren_i;
                st_load[0]  <= id_is_load_i;
                st_mdu[0]   <= id_is_mdu_i;
                st_rd[0]    <= id_rd_addr_i;
                ex_rs1      <= id_rs1_addr_i;
                ex_rs2      <= id_rs2_addr_i;
                ex_rs1_used <= id_rs1_used_i;
                ex_rs2_used <= id_rs2_used_i;
                mdu_cnt     <= (id_enter && id_is_mdu_i) ? MDU_LOAD : 5'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_unit
// Description : Directed and random checks of pipe_hazard_unit against a
//               behavioural pipeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;

    localparam int STAGES  = 3;
    localparam int MDU_LAT = 4;
    localparam int FWD_W   = $clog2(STAGES);

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             id_valid_i, id_rs1_used_i, id_rs2_used_i, id_rd_wren_i;
    logic             id_is_load_i, id_is_mdu_i, ex_br_taken_i;
    logic [4:0]       id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic             stall_pc_o, stall_ifid_o, flush_ifid_o, flush_idex_o;
    logic             hold_ex_o, bubble_mem_o, mdu_busy_o, mdu_done_o;
    logic [FWD_W-1:0] fwd_a_o, fwd_b_o;

    pipe_hazard_unit #(.STAGES(STAGES), .MDU_LAT(MDU_LAT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_addr_i(id_rd_addr_i), .id_rd_wren_i(id_rd_wren_i),
        .id_is_load_i(id_is_load_i), .id_is_mdu_i(id_is_mdu_i),
        .ex_br_taken_i(ex_br_taken_i),
        .stall_pc_o(stall_pc_o), .stall_ifid_o(stall_ifid_o),
        .flush_ifid_o(flush_ifid_o), .flush_idex_o(flush_idex_o),
        .hold_ex_o(hold_ex_o), .bubble_mem_o(bubble_mem_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .mdu_busy_o(mdu_busy_o), .mdu_done_o(mdu_done_o)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       mdu;
    } ins_t;

    ins_t pipe [STAGES];
    int   remaining;
    int   total = 0;
    int   bad   = 0;

    logic e_stall, e_flush_ifid, e_flush_idex, e_hold, e_done;
    int   e_fa, e_fb;
    int   s_fa, s_fb, s_stall, s_fifid, s_fidex, s_hold, s_busy, s_done;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit writes(ins_t i);
        return i.v && i.wr && (i.rd != 5'd0);
    endfunction

    function automatic ins_t mk(int rd, int wr, int rs1, int u1, int rs2, int u2, int ld, int mdu);
        ins_t i;
        i.v = 1'b1; i.rd = 5'(rd); i.wr = 1'(wr); i.rs1 = 5'(rs1); i.u1 = 1'(u1);
        i.rs2 = 5'(rs2); i.u2 = 1'(u2); i.ld = 1'(ld); i.mdu = 1'(mdu);
        return i;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < STAGES; k++) pipe[k] = '0;
        remaining = 0;
    endtask

    task automatic model_eval(input ins_t id, input logic br);
        bit busy, take_br, lu;
        busy    = remaining > 0;
        take_br = !busy && br && pipe[0].v;
        lu      = !busy && id.v && writes(pipe[0]) && pipe[0].ld &&
                  ((id.u1 && id.rs1 == pipe[0].rd) || (id.u2 && id.rs2 == pipe[0].rd));
        e_stall      = busy || (lu && !take_br);
        e_flush_ifid = take_br;
        e_flush_idex = take_br || lu;
        e_hold       = busy;
        e_done       = pipe[0].v && pipe[0].mdu && !busy;
        e_fa = 0;
        e_fb = 0;
        for (int k = 1; k < STAGES; k++) begin
            if (e_fa == 0 && pipe[0].v && pipe[0].u1 && writes(pipe[k]) && pipe[k].rd == pipe[0].rs1) e_fa = k;
            if (e_fb == 0 && pipe[0].v && pipe[0].u2 && writes(pipe[k]) && pipe[k].rd == pipe[0].rs2) e_fb = k;
        end
    endtask

    task automatic model_adv(input ins_t id);
        for (int k = STAGES - 1; k >= 1; k--) pipe[k] = pipe[k-1];
        if (remaining > 0) begin
            pipe[1] = '0;
            pipe[0] = pipe[0];
            remaining--;
        end else begin
            pipe[0] = (id.v && !e_flush_idex) ? id : '0;
            if (pipe[0].v && pipe[0].mdu) remaining = MDU_LAT - 1;
        end
    endtask

    task automatic cycle(input ins_t id, input logic br);
        @(negedge clk_i);
        id_valid_i = id.v;  id_rs1_addr_i = id.rs1; id_rs1_used_i = id.u1;
        id_rs2_addr_i = id.rs2; id_rs2_used_i = id.u2; id_rd_addr_i = id.rd;
        id_rd_wren_i = id.wr; id_is_load_i = id.ld; id_is_mdu_i = id.mdu;
        ex_br_taken_i = br;
        #1;
        model_eval(id, br);
        s_fa = int'(fwd_a_o); s_fb = int'(fwd_b_o); s_stall = int'(stall_pc_o);
        s_fifid = int'(flush_ifid_o); s_fidex = int'(flush_idex_o);
        s_hold = int'(hold_ex_o); s_busy = int'(mdu_busy_o); s_done = int'(mdu_done_o);
        chk("stall_pc",   int'(stall_pc_o),   int'(e_stall));
        chk("stall_ifid", int'(stall_ifid_o), int'(e_stall));
        chk("flush_ifid", int'(flush_ifid_o), int'(e_flush_ifid));
        chk("flush_idex", int'(flush_idex_o), int'(e_flush_idex));
        chk("hold_ex",    int'(hold_ex_o),    int'(e_hold));
        chk("bubble_mem", int'(bubble_mem_o), int'(e_hold));
        chk("mdu_busy",   int'(mdu_busy_o),   int'(e_hold));
        chk("mdu_done",   int'(mdu_done_o),   int'(e_done));
        chk("fwd_a",      int'(fwd_a_o),      e_fa);
        chk("fwd_b",      int'(fwd_b_o),      e_fb);
        @(posedge clk_i);
        model_adv(id);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outs"}, int'({stall_pc_o, stall_ifid_o, flush_ifid_o, flush_idex_o,
                                  hold_ex_o, bubble_mem_o, mdu_busy_o, mdu_done_o}), 0);
        chk({tag, "_fwd"}, int'({fwd_a_o, fwd_b_o}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_all_zero("reset");
        model_clear();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    ins_t nop, x, id;
    logic br, prev_stall, prev_flush;

    initial begin
        nop = '0;
        id_valid_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rs1_used_i = 0;
        id_rs2_used_i = 0; id_rd_addr_i = 0; id_rd_wren_i = 0; id_is_load_i = 0;
        id_is_mdu_i = 0; ex_br_taken_i = 0;
        model_clear();
        #2;
        check_all_zero("por");
        do_reset();

        // Back-to-back ALU forwarding, distance 1 then 2
        cycle(mk(5, 1, 1, 1, 2, 1, 0, 0), 0);
        cycle(mk(6, 1, 5, 1, 5, 1, 0, 0), 0);
        cycle(nop, 0);
        chk("b2b_fwd_a", s_fa, 1);
        chk("b2b_fwd_b", s_fb, 1);
        cycle(mk(5, 1, 1, 1, 2, 1, 0, 0), 0);
        cycle(mk(9, 1, 3, 1, 4, 1, 0, 0), 0);
        cycle(mk(6, 1, 5, 1, 5, 1, 0, 0), 0);
        cycle(nop, 0);
        chk("dist2_fwd_a", s_fa, 2);
        chk("dist2_fwd_b", s_fb, 2);

        // Load-use: one stall cycle, then consumer proceeds
        x = mk(8, 1, 7, 1, 0, 0, 0, 0);
        cycle(mk(7, 1, 1, 1, 0, 0, 1, 0), 0);
        cycle(x, 0);
        chk("lu_stall_pc", s_stall, 1);
        chk("lu_flush_idex", s_fidex, 1);
        cycle(x, 0);
        chk("lu_no_second_stall", s_stall, 0);
        cycle(nop, 0);
        chk("lu_fwd_a_nonzero", int'(s_fa != 0), 1);

        // Taken branch overrides load-use
        cycle(mk(7, 1, 1, 1, 0, 0, 1, 0), 0);
        cycle(x, 1);
        chk("br_lu_flush_ifid", s_fifid, 1);
        chk("br_lu_flush_idex", s_fidex, 1);
        chk("br_lu_stall_pc", s_stall, 0);
        cycle(nop, 0);
        chk("br_lu_after_stall", s_stall, 0);

        // MDU countdown
        x = mk(11, 1, 1, 1, 2, 1, 0, 0);
        cycle(mk(10, 1, 3, 1, 4, 1, 0, 1), 0);
        for (int i = 0; i < MDU_LAT - 1; i++) begin
            cycle(x, 1);
            chk("mdu_busy_cnt", s_busy, 1);
            chk("mdu_hold_cnt", s_hold, 1);
            chk("mdu_hold_noflush", s_fifid, 0);
        end
        cycle(x, 0);
        chk("mdu_done_last", s_done, 1);
        chk("mdu_busy_last", s_busy, 0);
        cycle(nop, 0);
        chk("mdu_done_cleared", s_done, 0);

        // x0 never forwards or stalls
        cycle(mk(0, 1, 1, 1, 0, 0, 0, 0), 0);
        cycle(mk(12, 1, 0, 1, 0, 1, 0, 0), 0);
        cycle(nop, 0);
        chk("x0_fwd_a", s_fa, 0);
        cycle(mk(0, 1, 1, 1, 0, 0, 1, 0), 0);
        cycle(mk(12, 1, 0, 1, 0, 1, 0, 0), 0);
        chk("x0_no_stall", s_stall, 0);

        // Reset in the second countdown cycle
        cycle(mk(10, 1, 3, 1, 4, 1, 0, 1), 0);
        cycle(nop, 0);
        do_reset();
        cycle(nop, 0);
        chk("post_reset_busy", s_busy, 0);

        // Randomized traffic with a front end that honours stall/flush
        prev_stall = 0;
        prev_flush = 0;
        id = nop;
        for (int n = 0; n < 800; n++) begin
            if (n == 400) begin
                do_reset();
                prev_stall = 0;
                prev_flush = 0;
            end
            if (prev_flush) begin
                id = nop;
            end else if (!prev_stall) begin
                id     = mk($urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 4),
                            $urandom_range(0, 1), $urandom_range(0, 4), $urandom_range(0, 1), 0, 0);
                id.v   = ($urandom_range(0, 7) != 0);
                id.mdu = ($urandom_range(0, 9) == 0);
                id.ld  = !id.mdu && ($urandom_range(0, 3) == 0);
            end
            br = ($urandom_range(0, 9) == 0);
            cycle(id, br);
            prev_stall = e_stall;
            prev_flush = e_flush_ifid;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
